wb_arbiter: RTL and testbench

- Round-robin Wishbone (pipelined, with stall) arbiter.
- Shares the MAC's single control slave port (2-bit address, 8-bit data) between NUM_MASTERS requesters, e.g. the existing wb_master and a future management/CPU master.
- Sits between the masters and mac in top.
- Bounds outstanding transactions and recovers from a hung slave via a timeout that raises err to the owning master.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_arbiter_rr_pick.sv | 34 +++
 rtl/wb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the MAC control-port arbiter.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 2;
  localparam int unsigned WB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_ABORT
  } wb_state_e;

  // Index reached by stepping off places past base, wrapping modulo n.
  function automatic int unsigned rr_next(input int unsigned base, input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after last_owner, wrapping.
module rr_pick
  import wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic               valid,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    idx   = '0;
    cand  = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'(rr_next(32'(last_owner), 32'(off), NUM_REQ));
      if (req[cand]) begin
        valid      = 1'b1;
        pick       = '0;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin pipelined Wishbone arbiter in front of the MAC control slave.
// Bounds outstanding strobes and aborts the owner with err on a hung slave.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned MAX_OUT     = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_MASTERS-1:0]           i_m_cyc,
  input  logic [NUM_MASTERS-1:0]           i_m_stb,
  input  logic [NUM_MASTERS-1:0]           i_m_we,
  input  logic [WB_ADDR_W*NUM_MASTERS-1:0] i_m_addr,
  input  logic [WB_DATA_W*NUM_MASTERS-1:0] i_m_data,
  output logic [NUM_MASTERS-1:0]           o_m_ack,
  output logic [NUM_MASTERS-1:0]           o_m_stall,
  output logic [NUM_MASTERS-1:0]           o_m_err,
  output logic [WB_DATA_W-1:0]             o_m_data,
  output logic [NUM_MASTERS-1:0]           o_grant,
  output logic                             o_s_cyc,
  output logic                             o_s_stb,
  output logic                             o_s_we,
  output logic [WB_ADDR_W-1:0]             o_s_addr,
  output logic [WB_DATA_W-1:0]             o_s_data,
  input  logic                             i_s_ack,
  input  logic                             i_s_stall,
  input  logic [WB_DATA_W-1:0]             i_s_data
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  wb_state_e              state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       last_owner_q;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NUM_MASTERS-1:0] err_q;

  logic                   pick_valid;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [IDX_W-1:0]       pick_idx;

  logic                   owner_cyc, owner_stb, owner_we;
  logic [WB_ADDR_W-1:0]   owner_addr;
  logic [WB_DATA_W-1:0]   owner_data;
  logic                   full, accept, timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (i_m_cyc),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .pick       (pick_onehot),
    .idx        (pick_idx)
  );

  // Select the current owner's request signals (last_owner doubles as owner index).
  always_comb begin
    owner_cyc  = 1'b0;
    owner_stb  = 1'b0;
    owner_we   = 1'b0;
    owner_addr = '0;
    owner_data = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (last_owner_q == IDX_W'(m)) begin
        owner_cyc  = i_m_cyc[m];
        owner_stb  = i_m_stb[m];
        owner_we   = i_m_we[m];
        owner_addr = i_m_addr[m*WB_ADDR_W +: WB_ADDR_W];
        owner_data = i_m_data[m*WB_DATA_W +: WB_DATA_W];
      end
    end
  end

  assign full = (outstanding_q == OUT_W'(MAX_OUT));

  // Slave-side pass-through and owner ack/stall routing; quiet unless owning.
  always_comb begin
    o_s_cyc   = 1'b0;
    o_s_stb   = 1'b0;
    o_s_we    = 1'b0;
    o_s_addr  = '0;
    o_s_data  = '0;
    o_m_ack   = '0;
    o_m_stall = '1;
    if (state_q == ST_OWN) begin
      o_s_cyc  = owner_cyc;
      o_s_stb  = owner_stb & ~full;
      o_s_we   = owner_we;
      o_s_addr = owner_addr;
      o_s_data = owner_data;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (last_owner_q == IDX_W'(m)) begin
          o_m_stall[m] = i_s_stall | full;
          o_m_ack[m]   = i_s_ack;
        end
      end
    end
  end

  assign accept   = o_s_stb & ~i_s_stall;
  assign o_m_data = i_s_data;
  assign o_grant  = grant_q;
  assign o_m_err  = err_q;

  // Outstanding counter and hang timer next-state (applied only while owning).
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !i_s_ack) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!accept && i_s_ack && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    timer_d = timer_q;
    if (i_s_ack || (outstanding_q == '0)) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 1'b1;
    end

    timeout_hit = (outstanding_q != '0) && !i_s_ack && (timer_q == TMR_W'(TIMEOUT - 1));
  end

  // Arbitration FSM with registered grant and error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_owner_q  <= IDX_W'(NUM_MASTERS - 1);
      outstanding_q <= '0;
      timer_q       <= '0;
      err_q         <= '0;
    end else begin
      err_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q       <= ST_OWN;
            grant_q       <= pick_onehot;
            last_owner_q  <= pick_idx;
            outstanding_q <= '0;
            timer_q       <= '0;
          end
        end
        ST_OWN: begin
          if (!owner_cyc) begin
            // Master released the bus; pending acks are abandoned.
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            outstanding_q <= '0;
            timer_q       <= '0;
          end else if (timeout_hit) begin
            state_q       <= ST_ABORT;
            err_q         <= grant_q;
            outstanding_q <= '0;
            timer_q       <= '0;
          end else begin
            outstanding_q <= outstanding_d;
            timer_q       <= timer_d;
          end
        end
        ST_ABORT: begin
          if (!owner_cyc) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: two masters, MAX_OUT=4, TIMEOUT=8.
module tb_wb_arbiter;

  localparam int unsigned NM      = 2;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned TIMEOUT = 8;

  logic          clk;
  logic          rstn;
  logic [NM-1:0] m_cyc, m_stb, m_we;
  logic [2*NM-1:0] m_addr;
  logic [8*NM-1:0] m_data;
  logic [NM-1:0] o_m_ack, o_m_stall, o_m_err, o_grant;
  logic [7:0]    o_m_data;
  logic          o_s_cyc, o_s_stb, o_s_we;
  logic [1:0]    o_s_addr;
  logic [7:0]    o_s_data;
  logic          s_ack, s_stall;
  logic [7:0]    s_data;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int err0     = 0;
  int err1     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_e;

  wb_arbiter #(
    .NUM_MASTERS (NM),
    .MAX_OUT     (MAX_OUT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_m_cyc   (m_cyc),
    .i_m_stb   (m_stb),
    .i_m_we    (m_we),
    .i_m_addr  (m_addr),
    .i_m_data  (m_data),
    .o_m_ack   (o_m_ack),
    .o_m_stall (o_m_stall),
    .o_m_err   (o_m_err),
    .o_m_data  (o_m_data),
    .o_grant   (o_grant),
    .o_s_cyc   (o_s_cyc),
    .o_s_stb   (o_s_stb),
    .o_s_we    (o_s_we),
    .o_s_addr  (o_s_addr),
    .o_s_data  (o_s_data),
    .i_s_ack   (s_ack),
    .i_s_stall (s_stall),
    .i_s_data  (s_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave-side monitor: every accepted strobe must match the queue head.
  always @(negedge clk) begin
    if (rstn && o_s_cyc && o_s_stb && !s_stall) begin
      n_acc++;
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        sb_e = exp_q.pop_front();
        check("sb_txn", 32'({o_s_we, o_s_addr, o_s_data}), sb_e);
      end
    end
    if (o_m_err[0]) err0++;
    if (o_m_err[1]) err1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [1:0] addr, input logic [7:0] data);
    m_cyc[k]          = cyc;
    m_stb[k]          = stb;
    m_we[k]           = we;
    m_addr[2*k +: 2]  = addr;
    m_data[8*k +: 8]  = data;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_data  = '0;
    s_ack   = 1'b0;
    s_stall = 1'b0;
    s_data  = 8'h3C;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic push_txn(input logic we, input logic [1:0] addr, input logic [7:0] data);
    exp_q.push_back(32'({we, addr, data}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_idx, pushed, acc0, e0, e1;

    // ---- Reset state and single write ----
    do_reset();
    sample();
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_stall", 32'(o_m_stall), 32'd3);
    check("rst_scyc", 32'(o_s_cyc), 32'd0);
    check("rst_sstb", 32'(o_s_stb), 32'd0);
    check("rst_ack", 32'(o_m_ack), 32'd0);
    check("rst_err", 32'(o_m_err), 32'd0);
    check("rdata_bcast", 32'(o_m_data), 32'h3C);
    tick();
    acc0 = n_acc; e0 = err0;
    set_m(0, 1'b1, 1'b1, 1'b1, 2'd2, 8'hA5);
    push_txn(1'b1, 2'd2, 8'hA5);
    sample();
    check("t1_lat0", 32'(o_grant), 32'd0);
    tick();
    sample();
    check("t1_grant", 32'(o_grant), 32'd1);
    check("t1_addr", 32'(o_s_addr), 32'd2);
    check("t1_data", 32'(o_s_data), 32'hA5);
    check("t1_stall", 32'(o_m_stall), 32'd2);
    tick();
    set_m(0, 1'b1, 1'b0, 1'b1, 2'd2, 8'hA5);
    s_ack = 1'b1;
    sample();
    check("t1_ack", 32'(o_m_ack), 32'd1);
    tick();
    s_ack = 1'b0;
    // Counter must be back at zero: no timeout while cyc is held idle.
    repeat (TIMEOUT + 4) tick();
    check("t1_no_err", 32'(err0 - e0), 32'd0);
    check("t1_acc", 32'(n_acc - acc0), 32'd1);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    set_m(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    tick();

    // ---- Simultaneous requests, bubble, round-robin ----
    do_reset();
    set_m(0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    set_m(1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    sample();
    check("t2_lat0", 32'(o_grant), 32'd0);
    tick();
    sample();
    check("t2_first", 32'(o_grant), 32'd1);
    tick();
    set_m(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    sample();
    check("t2_cyc_drop", 32'(o_s_cyc), 32'd0);
    tick();
    sample();
    check("t2_bubble", 32'(o_grant), 32'd0);
    tick();
    sample();
    check("t2_second", 32'(o_grant), 32'd2);
    tick();
    set_m(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    set_m(0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    tick();
    tick();
    sample();
    check("t2_rr_back", 32'(o_grant), 32'd1);
    set_m(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    tick();

    // ---- Five strobes, no ack: MAX_OUT limit, then timeout abort ----
    do_reset();
    acc0 = n_acc; e1 = err1;
    s_idx = 0; pushed = -1;
    for (int c = 0; c <= 16; c++) begin
      if (c < 15) begin
        set_m(1, 1'b1, s_idx < 5, 1'b1, 2'(s_idx), 8'hC0 + 8'(s_idx));
        if (s_idx != pushed && s_idx < int'(MAX_OUT)) begin
          push_txn(1'b1, 2'(s_idx), 8'hC0 + 8'(s_idx));
          pushed = s_idx;
        end
      end else begin
        set_m(1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
      end
      s_ack = (c == 12);
      sample();
      check($sformatf("t3_grant_c%0d", c), 32'(o_grant),
            (c >= 1 && c <= 15) ? 32'd2 : 32'd0);
      check($sformatf("t3_stall_c%0d", c), 32'(o_m_stall[1]),
            (c >= 1 && c <= int'(MAX_OUT)) ? 32'd0 : 32'd1);
      check($sformatf("t4_err_c%0d", c), 32'(o_m_err),
            (c == 2 + int'(TIMEOUT)) ? 32'd2 : 32'd0);
      check($sformatf("t4_scyc_c%0d", c), 32'(o_s_cyc),
            (c >= 1 && c < 2 + int'(TIMEOUT)) ? 32'd1 : 32'd0);
      if (c == 12) check("t4_ack_ignored", 32'(o_m_ack), 32'd0);
      if (m_cyc[1] && m_stb[1] && !o_m_stall[1]) s_idx++;
      tick();
    end
    s_ack = 1'b0;
    check("t3_accepts", 32'(n_acc - acc0), 32'(MAX_OUT));
    check("t4_err_once", 32'(err1 - e1), 32'd1);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // ---- Accept and ack together for 10 cycles ----
    do_reset();
    acc0 = n_acc; e0 = err0;
    s_idx = 0; pushed = -1;
    for (int c = 0; c <= 17; c++) begin
      set_m(0, 1'b1, s_idx < 11, s_idx[0], 2'(s_idx), 8'h10 + 8'(s_idx));
      if (s_idx != pushed && s_idx < 11) begin
        push_txn(s_idx[0], 2'(s_idx), 8'h10 + 8'(s_idx));
        pushed = s_idx;
      end
      s_ack = (c >= 2 && c <= 12);
      sample();
      if (c >= 1) check($sformatf("t5_nofull_c%0d", c), 32'(o_m_stall[0]), 32'd0);
      if (c >= 2 && c <= 12) check($sformatf("t5_ack_c%0d", c), 32'(o_m_ack), 32'd1);
      if (m_cyc[0] && m_stb[0] && !o_m_stall[0]) s_idx++;
      tick();
    end
    s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    tick();
    tick();
    sample();
    check("t5_released", 32'(o_grant), 32'd0);
    check("t5_accepts", 32'(n_acc - acc0), 32'd11);
    check("t5_no_err", 32'(err0 - e0), 32'd0);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    tick();

    // ---- Reset while three strobes are outstanding ----
    do_reset();
    acc0 = n_acc; e0 = err0;
    s_idx = 0; pushed = -1;
    for (int c = 0; c <= 3; c++) begin
      set_m(0, 1'b1, s_idx < 3, 1'b1, 2'(s_idx), 8'h50 + 8'(s_idx));
      if (s_idx != pushed && s_idx < 3) begin
        push_txn(1'b1, 2'(s_idx), 8'h50 + 8'(s_idx));
        pushed = s_idx;
      end
      sample();
      if (m_cyc[0] && m_stb[0] && !o_m_stall[0]) s_idx++;
      tick();
    end
    set_m(0, 1'b1, 1'b0, 1'b1, 2'd0, 8'h00);
    rstn = 1'b0;
    #1;
    check("t6_async_cyc", 32'(o_s_cyc), 32'd0);
    check("t6_async_stb", 32'(o_s_stb), 32'd0);
    check("t6_async_grant", 32'(o_grant), 32'd0);
    check("t6_async_stall", 32'(o_m_stall), 32'd3);
    repeat (3) tick();
    rstn = 1'b1;
    for (int c = 0; c <= int'(TIMEOUT) + 4; c++) begin
      sample();
      if (c >= 1) check($sformatf("t6_regrant_c%0d", c), 32'(o_grant), 32'd1);
      tick();
    end
    check("t6_accepts", 32'(n_acc - acc0), 32'd3);
    check("t6_no_err", 32'(err0 - e0), 32'd0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    set_m(0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
